fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the Antares-R2 processor. Holds the program counter, issues word requests to instruction memory over a req/ack handshake, and hands each fetched instruction, its PC and PC+4 to decode through a one-entry valid/ready output register. Its `id_pc_plus4` output feeds the low-select input of the 32-bit 2:1 PC-source mux. That mux's output returns here as `redirect_pc` when a branch or jump is taken.

## Interface

**Parameters**
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Bits [1:0] must be 00.

**Ports**
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `redirect` input 1: taken branch or jump; flush and load `redirect_pc`.
- `redirect_pc` input 32: new PC from the PC-source mux. Bits [1:0] are ignored and treated as 00.
- `imem_req` output 1: fetch request to instruction memory.
- `imem_addr` output 32: word address of the request.
- `imem_ack` input 1: memory has completed the request; `imem_rdata` is valid this cycle.
- `imem_rdata` input 32: instruction word.
- `id_valid` output 1: output register holds an instruction.
- `id_ready` input 1: decode accepts the instruction this cycle.
- `id_instr` output 32: fetched instruction.
- `id_pc` output 32: address of `id_instr`.
- `id_pc_plus4` output 32: `id_pc` + 4.

## Operation

**State machine** (registered, 4 states):
- BOOT
  - State held while reset is asserted.
  - Always moves to REQ on the first edge after reset release.
- REQ
  - `imem_req`=1 and `imem_addr`=pc.
  - On `imem_ack`:
    - capture `imem_rdata` into `id_instr`; pc into `id_pc`; pc+4 into `id_pc_plus4`;
    - set `id_valid`=1, advance pc to pc+4, go to HOLD.
- HOLD
  - `imem_req`=0.
  - When `id_valid`&&`id_ready` (transfer), clear `id_valid` and go to REQ.
- DROP
  - A redirect arrived while a request was outstanding.
  - `imem_req`=1 and `imem_addr` are held at the old address.
  - On `imem_ack`, discard `imem_rdata` and go to REQ.

**Handshake rules**
- `imem_req` and `imem_addr` stay stable from assertion until the cycle `imem_ack` is sampled high.
- The request is never withdrawn without an ack.
- `imem_ack` is only meaningful while `imem_req`=1; it is ignored in BOOT and HOLD.
- `id_instr`, `id_pc` and `id_pc_plus4` are stable while `id_valid`=1 and not yet transferred.

**Redirect** (highest priority, sampled every edge)
- pc is loaded with {`redirect_pc`[31:2], 2'b00}.
- `id_valid` is cleared on the same edge, even if a transfer happens that cycle.
- Next state depends on the current state:
  - REQ with no ack this cycle: go to DROP.
  - REQ with ack this cycle: data is discarded; go to REQ at the new pc.
  - HOLD: go to REQ.
  - DROP: update pc and stay in DROP.
  - BOOT: update pc; go to REQ.

**Arithmetic**
- pc+4 is a 32-bit add that wraps modulo 2^32, so 32'hFFFF_FFFC+4 = 32'h0000_0000.
- pc[1:0] is always 00.

**Throughput:** at most one instruction every 2 cycles with a zero-wait memory (REQ, then HOLD with `id_ready`=1).

## Timing

**Reset values** (asynchronous, immediate on `rst_n`=0):
- state=BOOT, pc=`RESET_PC`
- `imem_req`=0, `imem_addr`=`RESET_PC`
- `id_valid`=0, `id_instr`=32'h0000_0000 (NOP), `id_pc`=0, `id_pc_plus4`=0

**Reset mid-operation**
- Any outstanding memory request is abandoned.
- Instruction memory must be reset by the same `rst_n`.

**Latencies**
- First `imem_req`=1 appears in the cycle after the first rising edge with `rst_n`=1.
- Ack sampled at edge N gives `id_valid`=1 from edge N, with data registered.
- Transfer at edge N gives the next `imem_req`=1 from edge N.
- Redirect at edge N with no outstanding request gives `imem_req`=1 with `imem_addr`=`redirect_pc` from edge N.
- Redirect with a request outstanding: the new address is issued the cycle after the old request's ack.

**Outputs**
- `imem_req` and `imem_addr` are decoded from state and pc only; they have no combinational path from inputs.
- `id_*` outputs are registered.

## Test plan

1. **Reset then zero-wait fetch.** Hold `rst_n`=0, release, tie `imem_ack`=`imem_req`, `id_ready`=1, rdata=addr^32'hA5A5_A5A5. Required:
   - addresses 0, 4, 8 issued;
   - each `id_instr` matches its `id_pc`;
   - `id_valid` asserted every 2nd cycle.
2. **Decode stall.** `id_ready`=0 for 5 cycles after the first instruction. Required:
   - `id_valid`, `id_instr` and `id_pc`=0 held constant;
   - `imem_req`=0 throughout;
   - the next request to addr 4 starts the cycle after `id_ready` rises.
3. **Redirect in HOLD.** `id_valid`=1 at pc 8, assert `redirect` with `redirect_pc`=32'h0000_0103. Required:
   - `id_valid`=0 next cycle;
   - next `imem_addr`=32'h0000_0100;
   - `id_pc_plus4`=32'h0000_0104 after that fetch.
4. **Redirect during outstanding request.** 3-cycle memory latency; redirect to 32'h40 in the first wait cycle. Required:
   - `imem_addr` holds the old address until ack;
   - returned data never reaches `id_valid`;
   - then a request to 32'h40 is issued.
5. **Simultaneous ack and redirect**, plus a second redirect in DROP. Required:
   - data is discarded;
   - the last redirect's address is fetched;
   - no stale `id_valid`.
6. **PC wrap.** Redirect to 32'hFFFF_FFFC. Required:
   - `id_pc`=32'hFFFF_FFFC and `id_pc_plus4`=0;
   - next `imem_addr`=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Holds the PC, fetches one word at a time over a req/ack memory handshake,
// and presents {instr, pc, pc+4} to decode through a one-entry output register.
//
// Handshakes:
//   imem: o_imem_req/o_imem_addr come from registered state only. They stay
//         stable until i_imem_ack is sampled high, and are never withdrawn
//         early. i_imem_ack is only looked at while o_imem_req=1.
//   id:   an instruction transfers on any rising edge where o_id_valid=1 and
//         i_id_ready=1. The o_id_* payload holds steady until that edge.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_id_valid,
  input  logic        i_id_ready,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_pc_plus4,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_old_addr;   // address of the request being drained in DROP
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc_plus4;

  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_plus4;
  logic        w_ack_in_req;
  logic        w_transfer;
  logic [1:0]  w_unused_rpc_lsb;

  // Redirect targets are word aligned; the low two bits are dropped.
  assign w_redirect_pc    = {i_redirect_pc[31:2], 2'b00};
  assign w_unused_rpc_lsb = i_redirect_pc[1:0];
  assign w_pc_plus4       = r_pc + 32'd4;
  assign w_ack_in_req     = (r_state == REQ) && i_imem_ack;
  assign w_transfer       = r_id_valid && i_id_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_next_state;
  end

  // Next-state logic; redirect takes priority over everything else.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      BOOT: w_next_state = REQ;
      REQ: begin
        if (i_redirect)      w_next_state = i_imem_ack ? REQ : DROP;
        else if (i_imem_ack) w_next_state = HOLD;
      end
      HOLD: begin
        if (i_redirect || w_transfer) w_next_state = REQ;
      end
      DROP: begin
        // The stale request finishes on ack; a fresh redirect only moves pc.
        if (i_imem_ack) w_next_state = REQ;
      end
      default: w_next_state = BOOT;
    endcase
  end

  // Memory request outputs decoded from state and registered addresses only.
  always_comb begin
    o_imem_req  = (r_state == REQ) || (r_state == DROP);
    o_imem_addr = (r_state == DROP) ? r_old_addr : r_pc;
  end

  // Program counter and the address held while draining a dropped request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_old_addr <= RESET_PC;
    end else begin
      if ((r_state == REQ) && i_redirect && !i_imem_ack) r_old_addr <= r_pc;
      if (i_redirect)        r_pc <= w_redirect_pc;
      else if (w_ack_in_req) r_pc <= w_pc_plus4;
    end
  end

  // One-entry output register toward decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_valid    <= 1'b0;
      r_id_instr    <= 32'h0000_0000;
      r_id_pc       <= 32'h0000_0000;
      r_id_pc_plus4 <= 32'h0000_0000;
    end else if (i_redirect) begin
      r_id_valid <= 1'b0;
    end else if (w_ack_in_req) begin
      r_id_valid    <= 1'b1;
      r_id_instr    <= i_imem_rdata;
      r_id_pc       <= r_pc;
      r_id_pc_plus4 <= w_pc_plus4;
    end else if ((r_state == HOLD) && w_transfer) begin
      r_id_valid <= 1'b0;
    end
  end

  assign o_id_valid    = r_id_valid;
  assign o_id_instr    = r_id_instr;
  assign o_id_pc       = r_id_pc;
  assign o_id_pc_plus4 = r_id_pc_plus4;
  assign o_state       = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: cycle table of inputs and hand-computed outputs for
// fetch_unit, followed by an asynchronous reset sequence mid-operation.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst_n;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        o_id_valid;
  logic        i_id_ready;
  logic [31:0] o_id_instr;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_pc_plus4;
  logic [1:0]  o_state;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_rdata (i_imem_rdata),
    .o_id_valid   (o_id_valid),
    .i_id_ready   (i_id_ready),
    .o_id_instr   (o_id_instr),
    .o_id_pc      (o_id_pc),
    .o_id_pc_plus4(o_id_pc_plus4),
    .o_state      (o_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        ack;
    logic        rdy;
    logic [1:0]  e_st;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vec[40];
  int   n_vec = 0;

  task automatic add(input logic rd, input logic [31:0] rpc, input logic ack,
                     input logic rdy, input logic [1:0] st, input logic req,
                     input logic [31:0] addr, input logic valid,
                     input logic [31:0] pc, input logic [31:0] pc4);
    vec[n_vec].rd      = rd;
    vec[n_vec].rpc     = rpc;
    vec[n_vec].ack     = ack;
    vec[n_vec].rdy     = rdy;
    vec[n_vec].e_st    = st;
    vec[n_vec].e_req   = req;
    vec[n_vec].e_addr  = addr;
    vec[n_vec].e_valid = valid;
    vec[n_vec].e_pc    = pc;
    vec[n_vec].e_pc4   = pc4;
    n_vec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  // Driver: inputs for the upcoming edge; read data mirrors the expected address.
  task automatic drive(input int i);
    i_redirect    = vec[i].rd;
    i_redirect_pc = vec[i].rpc;
    i_imem_ack    = vec[i].ack;
    i_id_ready    = vec[i].rdy;
    i_imem_rdata  = vec[i].e_addr ^ K;
  endtask

  initial begin
    // Reset then zero-wait fetch, with a 5-cycle decode stall on the first word.
    add(0, 0, 0, 0, 2'd0, 0, 32'h0,   0, 32'h0, 32'h0);
    add(0, 0, 1, 0, 2'd1, 1, 32'h0,   0, 32'h0, 32'h0);
    for (int s = 0; s < 5; s++)
      add(0, 0, 0, 0, 2'd2, 0, 32'h0, 1, 32'h0, 32'h4);
    add(0, 0, 0, 1, 2'd2, 0, 32'h0,   1, 32'h0, 32'h4);
    add(0, 0, 1, 1, 2'd1, 1, 32'h4,   0, 32'h0, 32'h0);
    add(0, 0, 0, 1, 2'd2, 0, 32'h0,   1, 32'h4, 32'h8);
    add(0, 0, 1, 1, 2'd1, 1, 32'h8,   0, 32'h0, 32'h0);
    // Redirect in HOLD (with a simultaneous transfer), one wait cycle.
    add(1, 32'h103, 0, 1, 2'd2, 0, 32'h0, 1, 32'h8, 32'hC);
    add(0, 0, 0, 1, 2'd1, 1, 32'h100, 0, 32'h0, 32'h0);
    add(0, 0, 1, 1, 2'd1, 1, 32'h100, 0, 32'h0, 32'h0);
    add(0, 0, 0, 1, 2'd2, 0, 32'h0,   1, 32'h100, 32'h104);
    // Redirect while a 3-wait request is outstanding.
    add(1, 32'h40, 0, 1, 2'd1, 1, 32'h104, 0, 32'h0, 32'h0);
    add(0, 0, 0, 1, 2'd3, 1, 32'h104, 0, 32'h0, 32'h0);
    add(0, 0, 0, 1, 2'd3, 1, 32'h104, 0, 32'h0, 32'h0);
    add(0, 0, 1, 1, 2'd3, 1, 32'h104, 0, 32'h0, 32'h0);
    add(0, 0, 0, 1, 2'd1, 1, 32'h40,  0, 32'h0, 32'h0);
    // Ack together with redirect, then a second redirect while in DROP.
    add(1, 32'h200, 1, 1, 2'd1, 1, 32'h40,  0, 32'h0, 32'h0);
    add(1, 32'h300, 0, 1, 2'd1, 1, 32'h200, 0, 32'h0, 32'h0);
    add(1, 32'h380, 0, 1, 2'd3, 1, 32'h200, 0, 32'h0, 32'h0);
    add(0, 0, 1, 1, 2'd3, 1, 32'h200, 0, 32'h0, 32'h0);
    add(0, 0, 1, 1, 2'd1, 1, 32'h380, 0, 32'h0, 32'h0);
    // PC wrap.
    add(1, 32'hFFFF_FFFC, 0, 1, 2'd2, 0, 32'h0, 1, 32'h380, 32'h384);
    add(0, 0, 1, 1, 2'd1, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
    add(0, 0, 0, 1, 2'd2, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'h0);
    add(0, 0, 1, 0, 2'd1, 1, 32'h0,   0, 32'h0, 32'h0);
    add(0, 0, 0, 0, 2'd2, 0, 32'h0,   1, 32'h0, 32'h4);

    rst_n = 1'b0;
    i_redirect = 1'b0; i_redirect_pc = '0; i_imem_ack = 1'b0;
    i_imem_rdata = '0; i_id_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", {30'd0, o_state}, 32'd0);
    check("rst_req",   {31'd0, o_imem_req}, 32'd0);
    check("rst_addr",  o_imem_addr, 32'h0);
    check("rst_valid", {31'd0, o_id_valid}, 32'd0);
    check("rst_instr", o_id_instr, 32'h0);
    check("rst_pc",    o_id_pc, 32'h0);
    check("rst_pc4",   o_id_pc_plus4, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < n_vec; i++) begin
      if (i > 0) @(negedge clk);
      drive(i);
      #1;
      check($sformatf("v%0d_state", i), {30'd0, o_state}, {30'd0, vec[i].e_st});
      check($sformatf("v%0d_req", i), {31'd0, o_imem_req}, {31'd0, vec[i].e_req});
      if (vec[i].e_req) check($sformatf("v%0d_addr", i), o_imem_addr, vec[i].e_addr);
      check($sformatf("v%0d_valid", i), {31'd0, o_id_valid}, {31'd0, vec[i].e_valid});
      if (vec[i].e_valid) begin
        check($sformatf("v%0d_pc", i), o_id_pc, vec[i].e_pc);
        check($sformatf("v%0d_pc4", i), o_id_pc_plus4, vec[i].e_pc4);
        check($sformatf("v%0d_instr", i), o_id_instr, vec[i].e_pc ^ K);
      end
    end

    // Asynchronous reset in HOLD: outputs clear without waiting for an edge.
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", {30'd0, o_state}, 32'd0);
    check("arst_req",   {31'd0, o_imem_req}, 32'd0);
    check("arst_valid", {31'd0, o_id_valid}, 32'd0);
    check("arst_instr", o_id_instr, 32'h0);
    check("arst_pc4",   o_id_pc_plus4, 32'h0);
    i_id_ready = 1'b1; i_imem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_state", {30'd0, o_state}, 32'd0);
    check("rel_req",   {31'd0, o_imem_req}, 32'd0);
    @(negedge clk);
    #1;
    check("rel_req1",  {31'd0, o_imem_req}, 32'd1);
    check("rel_addr",  o_imem_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
